// File: rtl/ula_wb_buffer.sv
// Writeback skid buffer behind the ALU: 2-entry FIFO of results plus the
// architectural flags register with sticky overflow / divide-by-zero bits.
module ula_wb_buffer #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int FLAGS_WIDTH    = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [FLAGS_WIDTH-1:0]    in_rflags,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_wr_en,
  input  logic                      in_is_cmp,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      out_wr_en,
  output logic [FLAGS_WIDTH-1:0]    flags,
  output logic                      exc_pending,
  input  logic                      exc_clear
);

  localparam int FLAG_OVF = 4;
  localparam int FLAG_DBZ = 0;

  logic [DATA_WIDTH-1:0]     ent_data [2];
  logic [REG_ADDR_WIDTH-1:0] ent_rd   [2];
  logic [1:0]                ent_we;
  logic                      head;
  logic                      tail;
  logic [1:0]                count;
  logic [1:0]                count_next;
  logic                      ready_q;
  logic [FLAGS_WIDTH-1:0]    flags_q;
  logic [FLAGS_WIDTH-1:0]    flags_next;
  logic                      push;
  logic                      pop;

  assign push      = in_valid & ready_q;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Sticky bits: a set arriving with this push beats a simultaneous clear.
  always_comb begin
    flags_next = flags_q;
    if (push && in_is_cmp) begin
      flags_next[3:1] = in_rflags[3:1];
    end
    flags_next[FLAG_OVF] = (flags_q[FLAG_OVF] & ~exc_clear) | (push & in_rflags[FLAG_OVF]);
    flags_next[FLAG_DBZ] = (flags_q[FLAG_DBZ] & ~exc_clear) | (push & in_rflags[FLAG_DBZ]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= 2'd0;
      head        <= 1'b0;
      tail        <= 1'b0;
      ready_q     <= 1'b0;
      flags_q     <= '0;
      ent_data[0] <= '0;
      ent_data[1] <= '0;
      ent_rd[0]   <= '0;
      ent_rd[1]   <= '0;
      ent_we      <= 2'b00;
    end else begin
      count   <= count_next;
      ready_q <= (count_next != 2'd2);
      flags_q <= flags_next;
      if (push) begin
        ent_data[tail] <= in_data;
        ent_rd[tail]   <= in_rd;
        ent_we[tail]   <= in_wr_en & ~in_rflags[FLAG_DBZ];
        tail           <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
    end
  end

  // Outputs read as zero while empty so drained entries never show through.
  assign out_data    = out_valid ? ent_data[head] : '0;
  assign out_rd      = out_valid ? ent_rd[head]   : '0;
  assign out_wr_en   = out_valid & ent_we[head];
  assign in_ready    = ready_q;
  assign flags       = flags_q;
  assign exc_pending = flags_q[FLAG_OVF] | flags_q[FLAG_DBZ];

endmodule

// File: tb/tb_ula_wb_buffer.sv
// Directed bench for ula_wb_buffer: a vector table for handshake and flag
// behaviour, plus hand-written streaming and mid-operation reset sequences.
module tb_ula_wb_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [4:0]  in_rflags;
  logic [3:0]  in_rd;
  logic        in_wr_en;
  logic        in_is_cmp;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_rd;
  logic        out_wr_en;
  logic [4:0]  flags;
  logic        exc_pending;
  logic        exc_clear;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ula_wb_buffer #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(4), .FLAGS_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_rflags(in_rflags), .in_rd(in_rd), .in_wr_en(in_wr_en), .in_is_cmp(in_is_cmp),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_wr_en(out_wr_en),
    .flags(flags), .exc_pending(exc_pending), .exc_clear(exc_clear)
  );

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic [4:0]  rf;
    logic [3:0]  rd;
    logic        we;
    logic        cmp;
    logic        ordy;
    logic        clr;
    logic        e_ov;
    logic [15:0] e_od;
    logic [3:0]  e_rd;
    logic        e_we;
    logic        e_ir;
    logic [4:0]  e_fl;
    logic        e_exc;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(logic iv, logic [15:0] d, logic [4:0] rf, logic [3:0] rd,
                              logic we, logic cmp, logic ordy, logic clr,
                              logic e_ov, logic [15:0] e_od, logic [3:0] e_rd, logic e_we,
                              logic e_ir, logic [4:0] e_fl, logic e_exc);
    vec_t v;
    v.iv = iv; v.d = d; v.rf = rf; v.rd = rd; v.we = we; v.cmp = cmp;
    v.ordy = ordy; v.clr = clr; v.e_ov = e_ov; v.e_od = e_od; v.e_rd = e_rd;
    v.e_we = e_we; v.e_ir = e_ir; v.e_fl = e_fl; v.e_exc = e_exc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic ov, input logic [15:0] od,
                           input logic [3:0] ord, input logic owe, input logic ir,
                           input logic [4:0] fl, input logic exc);
    check({tag, ".out_valid"},   32'(out_valid),   32'(ov));
    check({tag, ".out_data"},    32'(out_data),    32'(od));
    check({tag, ".out_rd"},      32'(out_rd),      32'(ord));
    check({tag, ".out_wr_en"},   32'(out_wr_en),   32'(owe));
    check({tag, ".in_ready"},    32'(in_ready),    32'(ir));
    check({tag, ".flags"},       32'(flags),       32'(fl));
    check({tag, ".exc_pending"}, 32'(exc_pending), 32'(exc));
  endtask

  task automatic drive(input logic iv, input logic [15:0] d, input logic [4:0] rf,
                       input logic [3:0] rd, input logic we, input logic cmp,
                       input logic ordy, input logic clr);
    in_valid = iv; in_data = d; in_rflags = rf; in_rd = rd; in_wr_en = we;
    in_is_cmp = cmp; out_ready = ordy; exc_clear = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 16'h0, 5'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;

    //     iv  data      rflags    rd   we cmp ordy clr | ov  out_data  rd   we ir flags    exc
    vecs[0]  = mk(1, 16'h1234, 5'b00000, 4'd3, 1, 0, 0, 0,  1, 16'h1234, 4'd3, 1, 1, 5'b00000, 0);
    vecs[1]  = mk(0, 16'h0000, 5'b00000, 4'd0, 0, 0, 1, 0,  0, 16'h0000, 4'd0, 0, 1, 5'b00000, 0);
    vecs[2]  = mk(1, 16'h0001, 5'b00000, 4'd1, 1, 0, 0, 0,  1, 16'h0001, 4'd1, 1, 1, 5'b00000, 0);
    vecs[3]  = mk(1, 16'h0002, 5'b00000, 4'd2, 1, 0, 0, 0,  1, 16'h0001, 4'd1, 1, 0, 5'b00000, 0);
    vecs[4]  = mk(1, 16'h0003, 5'b10001, 4'd9, 1, 1, 0, 0,  1, 16'h0001, 4'd1, 1, 0, 5'b00000, 0);
    vecs[5]  = mk(0, 16'h0000, 5'b00000, 4'd0, 0, 0, 1, 0,  1, 16'h0002, 4'd2, 1, 1, 5'b00000, 0);
    vecs[6]  = mk(0, 16'h0000, 5'b00000, 4'd0, 0, 0, 1, 0,  0, 16'h0000, 4'd0, 0, 1, 5'b00000, 0);
    vecs[7]  = mk(1, 16'h0010, 5'b00100, 4'd4, 0, 1, 0, 0,  1, 16'h0010, 4'd4, 0, 1, 5'b00100, 0);
    vecs[8]  = mk(1, 16'h0011, 5'b01000, 4'd5, 1, 0, 1, 0,  1, 16'h0011, 4'd5, 1, 1, 5'b00100, 0);
    vecs[9]  = mk(1, 16'h0012, 5'b00010, 4'd6, 1, 1, 1, 0,  1, 16'h0012, 4'd6, 1, 1, 5'b00010, 0);
    vecs[10] = mk(1, 16'h0013, 5'b00001, 4'd7, 1, 0, 1, 0,  1, 16'h0013, 4'd7, 0, 1, 5'b00011, 1);
    vecs[11] = mk(1, 16'h0014, 5'b10000, 4'd8, 1, 0, 1, 0,  1, 16'h0014, 4'd8, 1, 1, 5'b10011, 1);
    vecs[12] = mk(1, 16'h0015, 5'b00001, 4'd9, 1, 0, 1, 1,  1, 16'h0015, 4'd9, 0, 1, 5'b00011, 1);
    vecs[13] = mk(0, 16'h0000, 5'b00000, 4'd0, 0, 0, 1, 1,  0, 16'h0000, 4'd0, 0, 1, 5'b00010, 0);

    #12;
    check_all("reset", 0, 16'h0, 4'h0, 0, 0, 5'b0, 0);
    rst_n = 1'b1;
    step();
    check_all("post_reset", 0, 16'h0, 4'h0, 0, 1, 5'b0, 0);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].rf, vecs[i].rd, vecs[i].we, vecs[i].cmp,
            vecs[i].ordy, vecs[i].clr);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_od, vecs[i].e_rd,
                vecs[i].e_we, vecs[i].e_ir, vecs[i].e_fl, vecs[i].e_exc);
    end

    // Streaming: push and pop every cycle, one result per cycle in order.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'h0100 + 16'(i), 5'b0, 4'(i), 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      check_all($sformatf("stream%0d", i), 1, 16'h0100 + 16'(i), 4'(i), 1, 1, 5'b00010, 0);
    end
    drive(1'b0, 16'h0, 5'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_all("stream_drain", 0, 16'h0, 4'h0, 0, 1, 5'b00010, 0);

    // Fill to count=2 with flags=10100, then reset between edges.
    drive(1'b1, 16'hAAAA, 5'b10100, 4'd10, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'hBBBB, 5'b00000, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_all("prefill", 1, 16'hAAAA, 4'd10, 1, 0, 5'b10100, 1);
    drive(1'b0, 16'h0, 5'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_reset", 0, 16'h0, 4'h0, 0, 0, 5'b0, 0);
    #1 rst_n = 1'b1;
    step();
    check_all("after_reset0", 0, 16'h0, 4'h0, 0, 1, 5'b0, 0);
    step();
    check_all("after_reset1", 0, 16'h0, 4'h0, 0, 1, 5'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
